led_reg_arbiter: RTL and testbench
==================================

# led_reg_arbiter

Round-robin arbiter that shares the single 4-bit LED register between several requesters: buttons, switch mirror, pattern generator and debug. It accepts one 4-bit value per grant over a valid/ready handshake and drives the register's enable/data pair for one cycle. It then enforces a minimum hold time so every written pattern stays visible before the next write. It sits directly in front of the 4-bit enable register that feeds the board LEDs.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 8, minimum cycles spent in HOLD after each write (0 allowed)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_val  in  NUM_REQ  per-requester valid
- req_data  in  4*NUM_REQ  per-requester value; requester i occupies bits [4i+3:4i]
- req_rdy  out  NUM_REQ  per-requester ready; at most one bit set (one-hot or zero)
- reg_en  out  1  write enable to LED register, registered
- reg_d  out  4  write data to LED register, registered
- grant_id  out  $clog2(NUM_REQ)  index of the most recently granted requester, registered
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, WRITE, HOLD.
- IDLE:
  - Winner = first i with req_val[i], searching upward (mod NUM_REQ) from ptr+1.
  - req_rdy[winner] = 1, combinational from req_val and ptr; all other req_rdy bits 0.
  - A transfer occurs when any req_val is set.
  - On transfer: data_q <= winner's req_data; grant_id <= winner; ptr <= winner; go to WRITE.
  - With no req_val set, stay in IDLE and keep all req_rdy at 0.
- WRITE:
  - reg_en = 1 and reg_d = data_q for exactly one cycle.
  - Go to HOLD with cnt = HOLD_CYCLES-1; if HOLD_CYCLES == 0, go directly to IDLE.
- HOLD: cnt decrements each cycle; at cnt == 0 go to IDLE. req_rdy stays all 0.
- reg_en is 0 in every state except WRITE. reg_d holds its last written value, including while reg_en = 0.
- Requesters may change req_data or drop req_val at any time before their transfer. The arbiter samples only in the transfer cycle.
- Reset values:
  - state IDLE, reg_en 0, reg_d 4'h0, grant_id 0, busy 0, cnt 0, data_q 0.
  - ptr = NUM_REQ-1, so requester 0 has priority after reset.
- Reset asserted mid-operation (WRITE or HOLD): return to the reset values on the next evaluation. The captured value is discarded, and reg_en must not pulse after reset deasserts.

## Timing
- Transfer in cycle T. reg_en = 1 in T+1. The LED register output changes after the edge ending T+1.
- HOLD occupies T+2 .. T+1+HOLD_CYCLES. The earliest next transfer is T+2+HOLD_CYCLES, giving a throughput of one write per HOLD_CYCLES+2 cycles.
- busy rises in T+1 and falls in T+2+HOLD_CYCLES, the cycle IDLE is re-entered.
- Wrap-around: after a grant to NUM_REQ-1, the search starts at 0.
- Simultaneous requests: each persistently requesting requester is granted at most once per NUM_REQ grants. There is no starvation.
- A single active requester is re-granted on every IDLE visit.

## Structure
- Shared package led_arb_pkg holds:
  - the typedef for the state enum (IDLE, WRITE, HOLD);
  - the constant LED_W = 4;
  - a function computing the counter width from HOLD_CYCLES (minimum 1 bit).
- Sub-module led_rr_pick: purely combinational round-robin picker.
  - Inputs: req vector and ptr. Outputs: one-hot grant, encoded index, any.
  - The top level contains only the FSM, the counter and the output registers.

## Test plan
- Reset, then no requests for 20 cycles -> reg_en never 1, reg_d = 0, busy = 0, req_rdy = 0.
- NUM_REQ=4, HOLD_CYCLES=8; req_val=4'b0001, req_data[3:0]=4'hA at T -> req_rdy[0]=1 at T, reg_en=1 and reg_d=A at T+1, busy falls at T+10.
- All four requesters hold req_val continuously with data 1,2,3,4 -> grant order 0,1,2,3,0 and reg_d sequence 1,2,3,4,1, with writes exactly 10 cycles apart.
- HOLD_CYCLES=0, requester 2 continuously valid -> reg_en pulses every 2nd cycle and grant_id stays 2.
- rst asserted during HOLD (cycle T+4), deasserted 2 cycles later while req_val=4'b0100 -> next grant goes to requester 2 (first valid from ptr reset), with no reg_en before that transfer.
- req_val for requester 1 drops in the same cycle requester 3 rises, with ptr=0 -> winner is 3, req_rdy=4'b1000.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED register arbiter.
// Holds the FSM state encoding, the LED width and the hold-counter sizing.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

    localparam int LED_W = 4;

    // The counter only ever holds HOLD_CYCLES-1, but it is never narrower than one bit.
    function automatic int cnt_width(input int hold_cycles);
        if (hold_cycles <= 2)
            return 1;
        else
            return $clog2(hold_cycles);
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker.
// The search begins one position above ptr and wraps modulo N.
module led_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = IW'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_reg_arbiter.sv
// Round-robin arbiter in front of the LED register.
// Each grant produces a one-cycle write, followed by a minimum hold before the next grant.
//
// state | meaning
// IDLE  | offering ready to the round-robin winner; a transfer occurs if any requester is valid
// WRITE | reg_en high for one cycle with the captured value
// HOLD  | counting down so the written pattern stays visible
module led_reg_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_val,
    input  logic [LED_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic                       reg_en,
    output logic [LED_W-1:0]           reg_d,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

    arb_state_t         state;
    arb_state_t         next_state;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      ptr;
    logic [LED_W-1:0]   data_q;
    logic               en_q;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               transfer;
    logic [LED_W-1:0]   pick_data;

    led_rr_pick #(.N(NUM_REQ)) u_pick (
        .req (req_val),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign transfer  = (state == IDLE) && pick_any;
    assign pick_data = req_data[int'(pick_idx)*LED_W +: LED_W];
    assign req_rdy   = (state == IDLE) ? pick_gnt : '0;
    assign busy      = (state != IDLE);
    assign reg_en    = en_q;
    assign reg_d     = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_any) next_state = WRITE;
            WRITE:   next_state = (HOLD_CYCLES == 0) ? IDLE : HOLD;
            HOLD:    if (cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // data_q doubles as reg_d, so the LED value persists between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            data_q   <= '0;
            grant_id <= '0;
            ptr      <= IW'(NUM_REQ - 1);
            cnt      <= '0;
        end else begin
            en_q <= transfer;
            if (transfer) begin
                data_q   <= pick_data;
                grant_id <= pick_idx;
                ptr      <= pick_idx;
            end
            if (state == WRITE)
                cnt <= CNT_LOAD;
            else if (state == HOLD && cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_led_reg_arbiter.sv
// Scoreboard bench for led_reg_arbiter: one instance with an 8-cycle hold, one with a zero-cycle hold.
// Expected writes are queued when stimulus is driven and popped whenever reg_en is observed.
module tb_led_reg_arbiter;
    import led_arb_pkg::*;

    localparam int N = 4;

    typedef struct {
        logic [3:0] d;
        logic [1:0] id;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_val;
    logic [N-1:0]   req_val_b;
    logic [4*N-1:0] req_data;
    logic [N-1:0]   rdy_a, rdy_b;
    logic           en_a, en_b;
    logic [3:0]     d_a, d_b;
    logic [1:0]     id_a, id_b;
    logic           busy_a, busy_b;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   wr_cyc[$];

    led_reg_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .req_val(req_val), .req_data(req_data),
        .req_rdy(rdy_a), .reg_en(en_a), .reg_d(d_a), .grant_id(id_a), .busy(busy_a)
    );

    led_reg_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req_val(req_val_b), .req_data(req_data),
        .req_rdy(rdy_b), .reg_en(en_b), .reg_d(d_b), .grant_id(id_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [3:0] d, input logic [1:0] id);
        exp_t e;
        e.d  = d;
        e.id = id;
        return e;
    endfunction

    // Advance one cycle, sample #1 after the edge, and score any write on dut_a.
    task automatic tick_mon();
        exp_t e;
        @(posedge clk);
        #1;
        if (en_a === 1'b1) begin
            wr_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write: reg_d=%h grant_id=%0d at cycle %0d, none expected", d_a, id_a, cyc);
            end else begin
                e = sb.pop_front();
                if (d_a !== e.d || id_a !== e.id) begin
                    errors++;
                    $display("FAIL sb_write: reg_d=%h grant_id=%0d, expected reg_d=%h grant_id=%0d", d_a, id_a, e.d, e.id);
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_val   = '0;
        req_val_b = '0;
        req_data  = '0;
        tick_mon();
        tick_mon();
        rst = 1'b0;
        sb.delete();
        wr_cyc.delete();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_a && n < 40) begin
            tick_mon();
            n++;
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, expected 0", name, busy_a, n);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            tick_mon();
            checks++;
            if ({en_a, d_a, busy_a, rdy_a, id_a} !== 12'h000) begin
                errors++;
                $display("FAIL reset_idle: reg_en=%b reg_d=%h busy=%b req_rdy=%b grant_id=%0d, expected all 0",
                         en_a, d_a, busy_a, rdy_a, id_a);
            end
        end
    endtask

    task automatic test_single();
        int t0;
        int n;
        apply_reset();
        req_data[3:0] = 4'hA;
        req_val       = 4'b0001;
        #1;
        checks++;
        if (rdy_a !== 4'b0001) begin
            errors++;
            $display("FAIL single_rdy: req_rdy=%b, expected 0001", rdy_a);
        end
        sb.push_back(mk(4'hA, 2'd0));
        t0 = cyc;
        tick_mon();
        req_val = '0;
        checks++;
        if (en_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL single_write_t1: reg_en=%b busy=%b, expected 1 1", en_a, busy_a);
        end
        n = 0;
        while (busy_a && n < 30) begin
            tick_mon();
            n++;
        end
        checks++;
        if (cyc - t0 != 10 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_fall: busy=%b fell at T+%0d, expected T+10", busy_a, cyc - t0);
        end
        checks++;
        if (d_a !== 4'hA || wr_cyc.size() != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL single_after: reg_d=%h writes=%0d pending=%0d, expected A 1 0", d_a, wr_cyc.size(), sb.size());
        end
    endtask

    task automatic test_round_robin();
        int n;
        apply_reset();
        req_data = 16'h4321;
        req_val  = 4'b1111;
        sb.push_back(mk(4'h1, 2'd0));
        sb.push_back(mk(4'h2, 2'd1));
        sb.push_back(mk(4'h3, 2'd2));
        sb.push_back(mk(4'h4, 2'd3));
        sb.push_back(mk(4'h1, 2'd0));
        #1;
        checks++;
        if (rdy_a !== 4'b0001) begin
            errors++;
            $display("FAIL rr_first_rdy: req_rdy=%b, expected 0001", rdy_a);
        end
        n = 0;
        while (wr_cyc.size() < 5 && n < 80) begin
            tick_mon();
            n++;
        end
        req_val = '0;
        checks++;
        if (wr_cyc.size() != 5 || sb.size() != 0) begin
            errors++;
            $display("FAIL rr_count: writes=%0d pending=%0d, expected 5 0", wr_cyc.size(), sb.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (wr_cyc[i] - wr_cyc[i-1] != 10) begin
                    errors++;
                    $display("FAIL rr_spacing: write %0d came %0d cycles after previous, expected 10", i, wr_cyc[i] - wr_cyc[i-1]);
                end
            end
        end
        wait_idle("rr");
    endtask

    task automatic test_hold0();
        int  t0;
        logic exp_en;
        apply_reset();
        req_data[11:8] = 4'h5;
        req_val_b      = 4'b0100;
        t0 = cyc;
        for (int k = 1; k <= 12; k++) begin
            tick_mon();
            exp_en = ((cyc - t0) % 2) == 1;
            checks++;
            if (en_b !== exp_en) begin
                errors++;
                $display("FAIL hold0_en: reg_en=%b at T+%0d, expected %b", en_b, cyc - t0, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (id_b !== 2'd2 || d_b !== 4'h5) begin
                    errors++;
                    $display("FAIL hold0_data: grant_id=%0d reg_d=%h, expected 2 5", id_b, d_b);
                end
            end
        end
        req_val_b = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_data[3:0] = 4'h3;
        req_val       = 4'b0001;
        sb.push_back(mk(4'h3, 2'd0));
        tick_mon();
        req_val = '0;
        tick_mon();
        tick_mon();
        tick_mon();
        rst = 1'b1;
        #1;
        checks++;
        if (busy_a !== 1'b0 || en_a !== 1'b0 || d_a !== 4'h0) begin
            errors++;
            $display("FAIL midrst_assert: busy=%b reg_en=%b reg_d=%h, expected 0 0 0", busy_a, en_a, d_a);
        end
        tick_mon();
        tick_mon();
        req_data[11:8] = 4'h7;
        req_val        = 4'b0100;
        rst            = 1'b0;
        #1;
        checks++;
        if (rdy_a !== 4'b0100 || en_a !== 1'b0 || d_a !== 4'h0) begin
            errors++;
            $display("FAIL midrst_release: req_rdy=%b reg_en=%b reg_d=%h, expected 0100 0 0", rdy_a, en_a, d_a);
        end
        sb.push_back(mk(4'h7, 2'd2));
        tick_mon();
        req_val = '0;
        checks++;
        if (en_a !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL midrst_grant: reg_en=%b pending=%0d, expected 1 0", en_a, sb.size());
        end
        wait_idle("midrst");
    endtask

    task automatic test_switch();
        apply_reset();
        req_data       = 16'h9063;
        req_val        = 4'b0001;
        sb.push_back(mk(4'h3, 2'd0));
        tick_mon();
        req_val = 4'b0010;
        tick_mon();
        #1;
        checks++;
        if (rdy_a !== 4'b0000) begin
            errors++;
            $display("FAIL switch_hold_rdy: req_rdy=%b during HOLD, expected 0000", rdy_a);
        end
        req_val = 4'b1000;
        wait_idle("switch");
        #1;
        checks++;
        if (rdy_a !== 4'b1000) begin
            errors++;
            $display("FAIL switch_rdy: req_rdy=%b, expected 1000", rdy_a);
        end
        sb.push_back(mk(4'h9, 2'd3));
        tick_mon();
        req_val = '0;
        checks++;
        if (en_a !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL switch_grant: reg_en=%b pending=%0d, expected 1 0", en_a, sb.size());
        end
        wait_idle("switch_end");
    endtask

    initial begin
        rst       = 1'b1;
        req_val   = '0;
        req_val_b = '0;
        req_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold0();
        test_reset_mid();
        test_switch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
